// File: rtl/fcvt_arbiter_if.sv
// Bus between the issue ports, the shared conversion units and the arbiter.
// Signal names follow the block's port list; clk/rst stay outside the bundle.
interface fcvt_arbiter_if #(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_op;
  logic [NREQ*32-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [31:0]          u_a;
  logic [31:0]          u_c_ftoi;
  logic [31:0]          u_c_itof;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [31:0]          res_data;
  logic                 busy;

  modport slave (
    input  hold, req_valid, req_op, req_data, u_c_ftoi, u_c_itof,
    output req_ready, u_a, res_valid, res_id, res_data, busy
  );

  modport master (
    output hold, req_valid, req_op, req_data, u_c_ftoi, u_c_itof,
    input  req_ready, u_a, res_valid, res_id, res_data, busy
  );
endinterface

// File: rtl/fcvt_arbiter.sv
// Round-robin arbiter sharing one ftoi/itof datapath between NREQ requesters,
// with an LAT-stage result pipeline tagged by requester id.
module fcvt_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT  = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic          clk,
  input  logic          rst,
  fcvt_arbiter_if.slave bus
);

  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
    int s;
    s = (int'(p) + k) % NREQ;
    return s[IDW-1:0];
  endfunction

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  gnt_id_s, idx_s;
  logic [NREQ-1:0] gnt_s;
  logic            found_s, hit_s, xfer_s;

  logic [31:0]     u_a_q;
  logic            op1_q, v1_q;
  logic [IDW-1:0]  id1_q;
  logic [31:0]     sel_s, res_data_s;
  logic [IDW-1:0]  res_id_s;
  logic            vlast_s, busy_s;

  // Round-robin grant: first valid requester after the last winner, with wrap.
  always_comb begin
    found_s  = 1'b0;
    hit_s    = 1'b0;
    idx_s    = '0;
    gnt_id_s = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_s    = rr_idx(ptr_q, k);
      hit_s    = ~found_s & bus.req_valid[idx_s];
      gnt_id_s = hit_s ? idx_s : gnt_id_s;
      found_s  = found_s | hit_s;
    end
    xfer_s = found_s & ~rst & ~bus.hold;
    gnt_s  = xfer_s ? (NREQ'(1) << gnt_id_s) : '0;
    ptr_d  = xfer_s ? gnt_id_s : ptr_q;
  end

  assign sel_s = op1_q ? bus.u_c_itof : bus.u_c_ftoi;

  // Stage 1: operand register feeding the conversion units, plus rr pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IDW'(NREQ - 1);
      u_a_q <= 32'h0;
      op1_q <= 1'b0;
      id1_q <= '0;
      v1_q  <= 1'b0;
    end else if (!bus.hold) begin
      ptr_q <= ptr_d;
      v1_q  <= xfer_s;
      if (xfer_s) begin
        u_a_q <= bus.req_data[32*int'(gnt_id_s) +: 32];
        op1_q <= bus.req_op[gnt_id_s];
        id1_q <= gnt_id_s;
      end
    end
  end

  if (LAT == 1) begin : g_direct
    assign res_data_s = sel_s;
    assign res_id_s   = id1_q;
    assign vlast_s    = v1_q;
    assign busy_s     = v1_q;
  end else begin : g_pipe
    logic [31:0]    sd_q  [LAT-1];
    logic [IDW-1:0] sid_q [LAT-1];
    logic [LAT-2:0] sv_q;

    // Result stages 2..LAT: capture the selected unit output, then shift.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int j = 0; j < LAT - 1; j++) begin
          sd_q[j]  <= 32'h0;
          sid_q[j] <= '0;
          sv_q[j]  <= 1'b0;
        end
      end else if (!bus.hold) begin
        sd_q[0]  <= sel_s;
        sid_q[0] <= id1_q;
        sv_q[0]  <= v1_q;
        for (int j = 1; j < LAT - 1; j++) begin
          sd_q[j]  <= sd_q[j-1];
          sid_q[j] <= sid_q[j-1];
          sv_q[j]  <= sv_q[j-1];
        end
      end
    end

    assign res_data_s = sd_q[LAT-2];
    assign res_id_s   = sid_q[LAT-2];
    assign vlast_s    = sv_q[LAT-2];
    assign busy_s     = v1_q | (|sv_q);
  end

  // A frozen result is suppressed while held so it emits once on release.
  assign bus.req_ready = gnt_s;
  assign bus.u_a       = u_a_q;
  assign bus.res_valid = vlast_s & ~bus.hold & ~rst;
  assign bus.res_id    = res_id_s;
  assign bus.res_data  = res_data_s;
  assign bus.busy      = busy_s;

endmodule

// File: tb/tb_fcvt_arbiter.sv
// Directed bench for fcvt_arbiter (NREQ=2, LAT=2) with a table-driven
// stand-in for the external ftoi/itof units.
module tb_fcvt_arbiter;
  localparam int NREQ = 2;
  localparam int LAT  = 2;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  logic rst;
  int   passes = 0;
  int   total  = 0;

  logic [31:0] fl [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                          32'h40800000, 32'h40A00000, 32'h40C00000};

  always #5 clk = ~clk;

  fcvt_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  fcvt_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] ftoi_m(input logic [31:0] a);
    case (a)
      32'h40200000: return 32'd3;
      32'hC0200000: return 32'hFFFFFFFD;
      32'h3F800000: return 32'd1;
      32'h40000000: return 32'd2;
      32'h40400000: return 32'd3;
      32'h40800000: return 32'd4;
      32'h40A00000: return 32'd5;
      32'h40C00000: return 32'd6;
      default:      return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] itof_m(input logic [31:0] a);
    case (a)
      32'd1:   return 32'h3F800000;
      32'd2:   return 32'h40000000;
      32'd3:   return 32'h40400000;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.u_c_ftoi = ftoi_m(bus.u_a);
  assign bus.u_c_itof = itof_m(bus.u_a);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] op,
                       input logic [31:0] d0, input logic [31:0] d1);
    bus.req_valid = v;
    bus.req_op    = op;
    bus.req_data  = {d1, d0};
  endtask

  // One cycle: inputs already driven; sample at the falling edge.
  task automatic step(input string tag, input logic [1:0] rdy, input logic b,
                      input logic v, input logic id, input logic [31:0] d);
    @(negedge clk);
    chk({tag, ".rdy"},  32'(bus.req_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(bus.busy),      32'(b));
    chk({tag, ".vld"},  32'(bus.res_valid), 32'(v));
    if (v) begin
      chk({tag, ".id"},   32'(bus.res_id), 32'(id));
      chk({tag, ".data"}, bus.res_data,    d);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    bus.hold = 1'b0;
    drive(2'b11, 2'b00, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    step("rst", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("rst.u_a",  bus.u_a, 32'h0);
    chk("rst.id",   32'(bus.res_id), 32'h0);
    chk("rst.data", bus.res_data, 32'h0);
    @(posedge clk);
    #1;

    // single ftoi from requester 0
    drive(2'b01, 2'b00, 32'h40200000, 32'h0);
    step("t1a", 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    step("t1b", 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t1.u_a", bus.u_a, 32'h40200000);
    step("t1c", 2'b00, 1'b1, 1'b1, 1'b0, 32'd3);
    step("t1d", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    // negative ftoi from requester 1, then itof from requester 0
    drive(2'b10, 2'b00, 32'h0, 32'hC0200000);
    step("t2a", 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    step("t2b", 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    step("t2c", 2'b00, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFD);
    drive(2'b01, 2'b01, 32'd3, 32'h0);
    step("t2d", 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    step("t2e", 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    step("t2f", 2'b00, 1'b1, 1'b1, 1'b0, 32'h40400000);

    // reset with both stages occupied
    drive(2'b10, 2'b00, 32'h0, 32'h40000000);
    step("t5a", 2'b10, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(2'b01, 2'b00, 32'h3F800000, 32'h0);
    step("t5b", 2'b01, 1'b1, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    drive(2'b11, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5.rdy_in_rst", 32'(bus.req_ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // both valid: alternate from requester 0, no stale results after reset
    for (int k = 0; k < 6; k++) begin
      drive(2'b11, 2'b00, fl[k], fl[k]);
      step($sformatf("t3_%0d", k), (k % 2 == 0) ? 2'b01 : 2'b10, k >= 1,
           k >= 2, 1'(k % 2), 32'(k - 1));
    end
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    step("t3_6", 2'b00, 1'b1, 1'b1, 1'b0, 32'd5);
    step("t3_7", 2'b00, 1'b1, 1'b1, 1'b1, 32'd6);
    step("t3_8", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    // hold for 3 cycles with two entries in flight
    drive(2'b01, 2'b00, 32'h3F800000, 32'h0);
    step("t4a", 2'b01, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(2'b10, 2'b00, 32'h0, 32'h40000000);
    step("t4b", 2'b10, 1'b1, 1'b0, 1'b0, 32'h0);
    bus.hold = 1'b1;
    drive(2'b11, 2'b00, 32'h3F800000, 32'h40000000);
    for (int k = 0; k < 3; k++) step($sformatf("t4h%0d", k), 2'b00, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("t4.u_a", bus.u_a, 32'h40000000);
    bus.hold = 1'b0;
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    step("t4c", 2'b00, 1'b1, 1'b1, 1'b0, 32'd1);
    step("t4d", 2'b00, 1'b1, 1'b1, 1'b1, 32'd2);
    step("t4e", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    // only requester 1 for 4 cycles, then requester 0 joins
    drive(2'b10, 2'b00, 32'h0, 32'h40800000);
    for (int k = 0; k < 4; k++)
      step($sformatf("t6_%0d", k), 2'b10, k >= 1, k >= 2, 1'b1, 32'd4);
    drive(2'b11, 2'b00, 32'h40A00000, 32'h40800000);
    step("t6_4", 2'b01, 1'b1, 1'b1, 1'b1, 32'd4);
    drive(2'b00, 2'b00, 32'h0, 32'h0);
    step("t6_5", 2'b00, 1'b1, 1'b1, 1'b1, 32'd4);
    step("t6_6", 2'b00, 1'b1, 1'b1, 1'b0, 32'd5);
    step("t6_7", 2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
